csdf_1p_4f_avg_repeat: RTL and testbench
========================================

Name: csdf_1p_4f_avg_repeat

Overview:
- Downstream CSDF actor for the 4-token accumulator stage. It consumes one sum token per firing.
- It divides the token by 2^SHIFT to form an average, then produces that average RATE times: one consume phase, RATE produce phases.
- Connects between two FIFOs using the team's rd/empty and wr/full handshake.

Parameters:
- WIDTH, 32, data width of input and output tokens (unsigned).
- RATE, 4, output tokens produced per input token; legal range 2..256.
- SHIFT, 2, right-shift applied to the input token (divide by 2^SHIFT); legal range 1..WIDTH-1.

Ports:
- ck  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in0_data  input  WIDTH  upstream FIFO read data; valid the cycle after in0_rd is asserted (registered-read FIFO).
- in0_empty  input  1  upstream FIFO empty.
- in0_rd  output  1  upstream FIFO read strobe.
- out0_full  input  1  downstream FIFO full.
- out0_wr  output  1  downstream FIFO write strobe.
- out0_data  output  WIDTH  token to downstream FIFO; sampled when out0_wr=1.

Behaviour:
- Reset:
  - state=IDLE, hold=0, cnt=0, out0_data=0.
  - in0_rd and out0_wr are forced 0 while rst=1.
  - Asserting rst mid-EMIT abandons the remaining phases; the pending token is lost and no further writes occur.
- State IDLE:
  - in0_rd = ~in0_empty; out0_wr=0.
  - If in0_empty=0, go to LOAD; otherwise stay in IDLE.
- State LOAD (read data now valid):
  - hold <= in0_data >> SHIFT, computed in WIDTH bits; cnt <= 0.
  - in0_rd=0, out0_wr=0; go to EMIT.
- State EMIT:
  - out0_data = hold, driven from a register with no combinational path from in0_data.
  - out0_wr = ~out0_full.
  - When a write occurs and cnt<RATE-1: cnt <= cnt+1; stay in EMIT.
  - When a write occurs and cnt==RATE-1 (last phase):
    - in0_rd = ~in0_empty in the same cycle.
    - If in0_empty=0, go to LOAD (back-to-back firing); otherwise go to IDLE.
    - cnt <= 0.
  - When out0_full=1: no write; hold, cnt and state are unchanged, and in0_rd=0.
- in0_rd is never asserted while in0_empty=1. out0_wr is never asserted while out0_full=1.
- Latency: the first output write occurs 2 cycles after the cycle in which in0_rd is asserted.
- Sustained throughput is 1 input token per RATE+1 cycles, due to one LOAD bubble per firing.
- out0_data holds its last value while in IDLE or LOAD.
- cnt width is $clog2(RATE). cnt never exceeds RATE-1, so it never wraps.

Optional Feature:
- Macro: CSDF_AVG_ROUND_EN.
- Defined: hold <= (in0_data + 2^(SHIFT-1)) >> SHIFT. The sum is computed in WIDTH+1 bits, so there is no overflow, and the result always fits in WIDTH.
- Undefined: truncating shift as specified in Behaviour.

Decomposition:
- Shared package csdf_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_LOAD=2'd1, ST_EMIT=2'd2.
  - a clog2 helper function.
- One sub-module: csdf_round_shift (parameters WIDTH and SHIFT; purely combinational). It holds the truncate or round divider so the divider can be reused by other averaging actors.
- The FSM, counter and hold register stay in the top module.

Test Plan:
- Single token, RATE=4, SHIFT=2: push 40 → in0_rd for 1 cycle, then after 2 cycles four consecutive writes of 10; return to IDLE with in0_rd=0.
- Rounding: push 42 → writes 10 x4 without the macro; writes 11 x4 with CSDF_AVG_ROUND_EN. Push 0xFFFFFFFF with the macro → writes 0x40000000 x4.
- Back-to-back: FIFO preloaded with 40 and 80 → in0_rd asserted in the same cycle as the 4th write of 10; next writes 20 x4; total 10 cycles from the first in0_rd to the last write.
- Backpressure: out0_full=1 for 3 cycles after the 2nd write → out0_wr=0 in those cycles; out0_data stays 10; the remaining 2 writes follow immediately after full deasserts; exactly 4 writes in total.
- Empty upstream at the end of a firing: in0_empty=1 on the 4th write → in0_rd=0, state goes to IDLE; a token pushed 5 cycles later starts a normal firing.
- Reset mid-EMIT: assert rst after the 2nd write of 10 → out0_wr=0 and out0_data=0 immediately; after release, no writes occur until a new token arrives.

Source files
------------

// File: rtl/csdf_pkg.sv
// Shared definitions for the CSDF averaging actors: state encoding and a clog2 helper.
package csdf_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      LOAD = ST_LOAD,
      EMIT = ST_EMIT
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/csdf_round_shift.sv
// Divide by 2^SHIFT, truncating by default or round-half-up when CSDF_AVG_ROUND_EN is defined.
module csdf_round_shift #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 2
) (
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

`ifdef CSDF_AVG_ROUND_EN
   // One extra bit keeps the rounding bias from overflowing.
   localparam logic [WIDTH:0] HALF = (WIDTH+1)'(1) << (SHIFT - 1);
   logic [WIDTH:0] sum;

   assign sum  = {1'b0, din} + HALF;
   assign dout = WIDTH'(sum >> SHIFT);
`else
   assign dout = din >> SHIFT;
`endif

endmodule

// File: rtl/csdf_1p_4f_avg_repeat.sv
// CSDF actor: consume one sum token, emit its 2^SHIFT average RATE times.
// Optional rounding divider via CSDF_AVG_ROUND_EN.
module csdf_1p_4f_avg_repeat
   import csdf_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int RATE  = 4,
   parameter int SHIFT = 2
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_empty,
   output logic             in0_rd,
   input  logic             out0_full,
   output logic             out0_wr,
   output logic [WIDTH-1:0] out0_data
);

   localparam int            CW   = clog2(RATE);
   localparam logic [CW-1:0] LAST = CW'(RATE - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] avg;
   logic [CW-1:0]    cnt;
   logic             rd_c, wr_c;

   csdf_round_shift #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_div (
      .din  (in0_data),
      .dout (avg)
   );

   always_ff @(posedge ck or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      rd_c     = 1'b0;
      wr_c     = 1'b0;
      case (state)
         IDLE: begin
            rd_c = ~in0_empty;
            if (!in0_empty) state_nx = LOAD;
         end
         LOAD: state_nx = EMIT;
         EMIT: begin
            wr_c = ~out0_full;
            // Last phase overlaps the next read so back-to-back firings lose only the LOAD bubble.
            if (!out0_full && cnt == LAST) begin
               rd_c     = ~in0_empty;
               state_nx = in0_empty ? IDLE : LOAD;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ck or posedge rst)
      if (rst) begin
         hold <= '0;
         cnt  <= '0;
      end else if (state == LOAD) begin
         hold <= avg;
         cnt  <= '0;
      end else if (state == EMIT && wr_c) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end

   assign in0_rd    = rd_c & ~rst;
   assign out0_wr   = wr_c & ~rst;
   assign out0_data = hold;

endmodule

// File: tb/tb_csdf_1p_4f_avg_repeat.sv
// Directed bench for csdf_1p_4f_avg_repeat (RATE=4, SHIFT=2) with a registered-read FIFO model.
module tb_csdf_1p_4f_avg_repeat;

   logic        ck = 1'b0;
   logic        rst;
   logic [31:0] in0_data;
   logic        in0_empty;
   logic        in0_rd;
   logic        out0_full;
   logic        out0_wr;
   logic [31:0] out0_data;

   int checks = 0;
   int errors = 0;
   int cn     = 0;

   logic [31:0] fifo[$];
   int          rd_log[$];
   int          wc[$];
   logic [31:0] wd[$];
   logic        s_rd, s_wr;
   logic [31:0] s_data;

   csdf_1p_4f_avg_repeat #(.WIDTH(32), .RATE(4), .SHIFT(2)) dut (
      .ck        (ck),
      .rst       (rst),
      .in0_data  (in0_data),
      .in0_empty (in0_empty),
      .in0_rd    (in0_rd),
      .out0_full (out0_full),
      .out0_wr   (out0_wr),
      .out0_data (out0_data)
   );

   always #5 ck = ~ck;

   // One clock: sample settled outputs, take the edge, then model the FIFO's registered read.
   task automatic cyc();
      #2;
      s_rd   = in0_rd;
      s_wr   = out0_wr;
      s_data = out0_data;
      if (s_rd) rd_log.push_back(cn);
      if (s_wr) begin
         wc.push_back(cn);
         wd.push_back(s_data);
      end
      checks++;
      if ((s_rd && in0_empty) || (s_wr && out0_full)) begin
         errors++;
         $display("FAIL handshake cycle %0d: rd=%0b empty=%0b wr=%0b full=%0b", cn, s_rd, in0_empty, s_wr, out0_full);
      end
      @(posedge ck);
      #1;
      cn++;
      if (s_rd && fifo.size() > 0) in0_data = fifo.pop_front();
      in0_empty = (fifo.size() == 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic push(input logic [31:0] v);
      fifo.push_back(v);
      in0_empty = 1'b0;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wc.delete();
      wd.delete();
   endtask

   task automatic check_writes(input string name, input int n, input logic [31:0] exp);
      checks++;
      if (wc.size() != n) begin
         errors++;
         $display("FAIL %s write count: got %0d want %0d", name, wc.size(), n);
      end
      for (int i = 0; i < wd.size() && i < n; i++) begin
         checks++;
         if (wd[i] !== exp) begin
            errors++;
            $display("FAIL %s data[%0d]: got %h want %h", name, i, wd[i], exp);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in0_empty = 1'b0; out0_full = 1'b0; in0_data = 32'hDEAD_BEEF;
      #2;
      checks++;
      if (in0_rd !== 1'b0 || out0_wr !== 1'b0 || out0_data !== 32'd0) begin
         errors++;
         $display("FAIL reset: rd=%b wr=%b data=%h want 0 0 0", in0_rd, out0_wr, out0_data);
      end
      in0_empty = 1'b1;
      @(posedge ck); #1;
      rst = 1'b0;
      run(2);
      clear_logs();
   endtask

   task automatic test_single();
      clear_logs();
      push(32'd40);
      run(10);
      check_writes("single", 4, 32'd10);
      checks++;
      if (rd_log.size() != 1 || wc.size() != 4) begin
         errors++;
         $display("FAIL single rd count: got %0d want 1", rd_log.size());
      end else begin
         checks++;
         if (wc[0] != rd_log[0] + 2) begin
            errors++;
            $display("FAIL single latency: got %0d want 2", wc[0] - rd_log[0]);
         end
         checks++;
         if (wc[3] != wc[0] + 3) begin
            errors++;
            $display("FAIL single consecutive: span %0d want 3", wc[3] - wc[0]);
         end
      end
      #2;
      checks++;
      if (in0_rd !== 1'b0 || out0_wr !== 1'b0 || out0_data !== 32'd10) begin
         errors++;
         $display("FAIL single idle: rd=%b wr=%b data=%h want 0 0 0000000a", in0_rd, out0_wr, out0_data);
      end
      @(posedge ck); #1; cn++;
   endtask

   task automatic test_round();
      clear_logs();
      push(32'd42);
      run(8);
`ifdef CSDF_AVG_ROUND_EN
      check_writes("round42", 4, 32'd11);
      clear_logs();
      push(32'hFFFF_FFFF);
      run(8);
      check_writes("roundmax", 4, 32'h4000_0000);
`else
      check_writes("trunc42", 4, 32'd10);
      clear_logs();
      push(32'hFFFF_FFFF);
      run(8);
      check_writes("truncmax", 4, 32'h3FFF_FFFF);
`endif
   endtask

   task automatic test_back_to_back();
      clear_logs();
      push(32'd40);
      push(32'd80);
      run(14);
      checks++;
      if (rd_log.size() != 2 || wc.size() != 8) begin
         errors++;
         $display("FAIL b2b counts: rd=%0d wr=%0d want 2 8", rd_log.size(), wc.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wd[i] !== ((i < 4) ? 32'd10 : 32'd20)) begin
               errors++;
               $display("FAIL b2b data[%0d]: got %0d want %0d", i, wd[i], (i < 4) ? 10 : 20);
            end
         end
         checks++;
         if (rd_log[1] != wc[3]) begin
            errors++;
            $display("FAIL b2b overlap: rd at %0d want %0d", rd_log[1], wc[3]);
         end
         checks++;
         if (wc[7] - rd_log[0] != 10) begin
            errors++;
            $display("FAIL b2b span: got %0d want 10", wc[7] - rd_log[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int nfull;
      clear_logs();
      nfull = 0;
      push(32'd40);
      for (int i = 0; i < 20 && wc.size() < 4; i++) begin
         out0_full = (wc.size() == 2 && nfull < 3);
         cyc();
         if (out0_full) begin
            nfull++;
            checks++;
            if (s_wr !== 1'b0 || s_data !== 32'd10) begin
               errors++;
               $display("FAIL backpressure stall: wr=%b data=%0d want 0 10", s_wr, s_data);
            end
         end
      end
      out0_full = 1'b0;
      run(2);
      check_writes("backpressure", 4, 32'd10);
      if (wc.size() == 4) begin
         checks++;
         if (wc[2] != wc[1] + 4 || wc[3] != wc[2] + 1) begin
            errors++;
            $display("FAIL backpressure resume: gaps %0d %0d want 4 1", wc[2] - wc[1], wc[3] - wc[2]);
         end
      end
   endtask

   task automatic test_empty_end();
      clear_logs();
      push(32'd40);
      run(8);
      check_writes("emptyend", 4, 32'd10);
      checks++;
      if (rd_log.size() != 1) begin
         errors++;
         $display("FAIL emptyend rd count: got %0d want 1", rd_log.size());
      end
      clear_logs();
      run(5);
      checks++;
      if (rd_log.size() != 0 || wc.size() != 0) begin
         errors++;
         $display("FAIL emptyend idle: rd=%0d wr=%0d want 0 0", rd_log.size(), wc.size());
      end
      push(32'd80);
      run(8);
      check_writes("emptyend2", 4, 32'd20);
      if (wc.size() == 4 && rd_log.size() == 1) begin
         checks++;
         if (wc[0] != rd_log[0] + 2) begin
            errors++;
            $display("FAIL emptyend2 latency: got %0d want 2", wc[0] - rd_log[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      push(32'd40);
      for (int i = 0; i < 10 && wc.size() < 2; i++) cyc();
      rst = 1'b1;
      #1;
      checks++;
      if (out0_wr !== 1'b0 || out0_data !== 32'd0 || in0_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset mid: wr=%b data=%h rd=%b want 0 0 0", out0_wr, out0_data, in0_rd);
      end
      @(posedge ck); #1; cn++;
      rst = 1'b0;
      clear_logs();
      run(6);
      checks++;
      if (wc.size() != 0 || rd_log.size() != 0) begin
         errors++;
         $display("FAIL reset mid quiet: wr=%0d rd=%0d want 0 0", wc.size(), rd_log.size());
      end
      push(32'd80);
      run(8);
      check_writes("reset mid new", 4, 32'd20);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round();
      test_back_to_back();
      test_backpressure();
      test_empty_end();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
